// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with a pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writes to the read ports.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*XLEN-1:0]   wr_data,
  input  logic                     rsv_valid,
  input  logic [AW-1:0]            rsv_addr,
  output logic [NREGS-1:0]         busy_vec
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;

  logic [NREGS-1:0] w_wen;
  logic [XLEN-1:0]  w_wdat [NREGS];
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_busy_nxt;

  // Later ports overwrite earlier ones, so the highest index wins.
  always_comb begin
    w_wen = '0;
    for (int r = 0; r < NREGS; r++) begin
      w_wdat[r] = '0;
    end
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w]) begin
        w_wen[wr_addr[w*AW +: AW]]  = 1'b1;
        w_wdat[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
      end
    end
    if (ZERO_REG != 0) begin
      w_wen[0] = 1'b0;
    end
  end

  always_comb begin
    w_set = '0;
    if (rsv_valid) begin
      w_set[rsv_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      w_set[0] = 1'b0;
    end
  end

  // A reservation beats a same-cycle clear: the newer issue owns the reg.
  assign w_busy_nxt = (r_busy & ~w_wen) | w_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        r_regs[r] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (w_wen[r]) begin
          r_regs[r] <= w_wdat[r];
        end
      end
      r_busy <= w_busy_nxt;
    end
  end

  assign busy_vec = r_busy;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0]   w_ra;
    logic [XLEN-1:0] w_rdat;
    logic            w_rbsy;

    assign w_ra = rd_addr[p*AW +: AW];

    always_comb begin
      w_rdat = r_regs[w_ra];
      w_rbsy = r_busy[w_ra];
`ifdef REGFILE_BYPASS_EN
      // Gated by rst_n so outputs stay at zero throughout reset.
      for (int w = 0; w < NUM_WR; w++) begin
        if (rst_n && wr_en[w] && (wr_addr[w*AW +: AW] == w_ra)) begin
          w_rdat = wr_data[w*XLEN +: XLEN];
          w_rbsy = rsv_valid && (rsv_addr == w_ra);
        end
      end
`endif
      if ((ZERO_REG != 0) && (w_ra == '0)) begin
        w_rdat = '0;
        w_rbsy = 1'b0;
      end
    end

    assign rd_data[p*XLEN +: XLEN] = w_rdat;
    assign rd_busy[p]              = w_rbsy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp with 3 read and 2 write ports.
// Expected values are queued at stimulus time and compared once outputs settle.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD   = 3;
  localparam int NWR   = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic [NWR-1:0]       wr_en;
  logic [NWR*AW-1:0]    wr_addr;
  logic [NWR*XLEN-1:0]  wr_data;
  logic                 rsv_valid;
  logic [AW-1:0]        rsv_addr;
  logic [NREGS-1:0]     busy_vec;

  regfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NRD), .NUM_WR(NWR), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  // sel 0..2: rd_data port, 3: busy_vec, 4: rd_busy
  typedef struct {
    int          sel;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  logic [31:0] m_regs [NREGS];
  logic [31:0] m_busy;

  function automatic logic [31:0] obs(int sel);
    logic [31:0] o;
    o = '0;
    if (sel < NRD) o = rd_data[sel*XLEN +: XLEN];
    else if (sel == 3) o = busy_vec;
    else o = {29'b0, rd_busy};
    return o;
  endfunction

  task automatic push(int s, logic [31:0] v);
    sb.push_back('{sel: s, v: v});
  endtask

  task automatic idle();
    wr_en     = '0;
    wr_addr   = '0;
    wr_data   = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(int p, logic [4:0] a, logic [31:0] d);
    wr_en[p]               = 1'b1;
    wr_addr[p*AW +: AW]    = a;
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic rsv(logic [4:0] a);
    rsv_valid = 1'b1;
    rsv_addr  = a;
  endtask

  task automatic setrd(logic [4:0] a0, logic [4:0] a1, logic [4:0] a2);
    rd_addr = {a2, a1, a0};
  endtask

  task automatic test_reset();
    exp_t x;
    rst_n = 1'b0;
    idle();
    setrd(5, 6, 31);
    push(0, 0); push(1, 0); push(2, 0); push(3, 0); push(4, 0);
    #2;
    while (sb.size() > 0) begin
      x = sb.pop_front(); n_total++;
      if (obs(x.sel) !== x.v)
        $display("FAIL reset_por sel%0d: got %h expected %h", x.sel, obs(x.sel), x.v);
      else n_pass++;
    end
    @(negedge clk) rst_n = 1'b1;
    cyc();
    wr(0, 5, 32'hDEADBEEF);
    rsv(6);
    push(0, 32'hDEADBEEF); push(3, 32'h40); push(4, 32'h2);
    cyc();
    idle();
    while (sb.size() > 0) begin
      x = sb.pop_front(); n_total++;
      if (obs(x.sel) !== x.v)
        $display("FAIL reset_pre sel%0d: got %h expected %h", x.sel, obs(x.sel), x.v);
      else n_pass++;
    end
    #1 rst_n = 1'b0;
    push(0, 0); push(3, 0); push(4, 0);
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front(); n_total++;
      if (obs(x.sel) !== x.v)
        $display("FAIL reset_async sel%0d: got %h expected %h", x.sel, obs(x.sel), x.v);
      else n_pass++;
    end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_write_latency();
    exp_t x;
    cyc();
    idle();
    wr(0, 3, 32'h12345678);
    wr(1, 0, 32'hFFFFFFFF);
    setrd(3, 0, 3);
`ifdef REGFILE_BYPASS_EN
    push(0, 32'h12345678);
`else
    push(0, 32'h0);
`endif
    push(1, 0);
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front(); n_total++;
      if (obs(x.sel) !== x.v)
        $display("FAIL lat_same sel%0d: got %h expected %h", x.sel, obs(x.sel), x.v);
      else n_pass++;
    end
    push(0, 32'h12345678); push(1, 0); push(2, 32'h12345678);
    cyc();
    idle();
    while (sb.size() > 0) begin
      x = sb.pop_front(); n_total++;
      if (obs(x.sel) !== x.v)
        $display("FAIL lat_next sel%0d: got %h expected %h", x.sel, obs(x.sel), x.v);
      else n_pass++;
    end
  endtask

  task automatic test_priority();
    exp_t x;
    cyc();
    idle();
    wr(0, 7, 32'hAAAA0000);
    wr(1, 7, 32'h5555FFFF);
    setrd(7, 7, 7);
    push(0, 32'h5555FFFF); push(1, 32'h5555FFFF); push(2, 32'h5555FFFF);
    cyc();
    idle();
    while (sb.size() > 0) begin
      x = sb.pop_front(); n_total++;
      if (obs(x.sel) !== x.v)
        $display("FAIL prio sel%0d: got %h expected %h", x.sel, obs(x.sel), x.v);
      else n_pass++;
    end
  endtask

  task automatic test_scoreboard();
    exp_t x;
    cyc();
    idle();
    rsv(9);
    setrd(9, 9, 9);
    push(4, 0);
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front(); n_total++;
      if (obs(x.sel) !== x.v)
        $display("FAIL sb_n sel%0d: got %h expected %h", x.sel, obs(x.sel), x.v);
      else n_pass++;
    end
    push(4, 32'h7); push(3, 32'h200);
    cyc();
    idle();
    while (sb.size() > 0) begin
      x = sb.pop_front(); n_total++;
      if (obs(x.sel) !== x.v)
        $display("FAIL sb_n1 sel%0d: got %h expected %h", x.sel, obs(x.sel), x.v);
      else n_pass++;
    end
    push(4, 32'h7);
    cyc();
    while (sb.size() > 0) begin
      x = sb.pop_front(); n_total++;
      if (obs(x.sel) !== x.v)
        $display("FAIL sb_n2 sel%0d: got %h expected %h", x.sel, obs(x.sel), x.v);
      else n_pass++;
    end
    cyc();
    wr(0, 9, 32'hCAFE0009);
`ifdef REGFILE_BYPASS_EN
    push(4, 32'h0);
`else
    push(4, 32'h7);
`endif
    push(3, 32'h200);
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front(); n_total++;
      if (obs(x.sel) !== x.v)
        $display("FAIL sb_n3 sel%0d: got %h expected %h", x.sel, obs(x.sel), x.v);
      else n_pass++;
    end
    push(4, 0); push(3, 0); push(0, 32'hCAFE0009);
    cyc();
    idle();
    while (sb.size() > 0) begin
      x = sb.pop_front(); n_total++;
      if (obs(x.sel) !== x.v)
        $display("FAIL sb_n4 sel%0d: got %h expected %h", x.sel, obs(x.sel), x.v);
      else n_pass++;
    end
    rsv(0);
    setrd(0, 0, 0);
    push(3, 0); push(4, 0);
    cyc();
    idle();
    while (sb.size() > 0) begin
      x = sb.pop_front(); n_total++;
      if (obs(x.sel) !== x.v)
        $display("FAIL sb_r0 sel%0d: got %h expected %h", x.sel, obs(x.sel), x.v);
      else n_pass++;
    end
  endtask

  task automatic test_collision();
    exp_t x;
    cyc();
    idle();
    rsv(4);
    setrd(4, 4, 4);
    push(3, 32'h10);
    cyc();
    idle();
    while (sb.size() > 0) begin
      x = sb.pop_front(); n_total++;
      if (obs(x.sel) !== x.v)
        $display("FAIL coll_pre sel%0d: got %h expected %h", x.sel, obs(x.sel), x.v);
      else n_pass++;
    end
    wr(0, 4, 32'h00000042);
    rsv(4);
    push(0, 32'h42); push(3, 32'h10); push(4, 32'h7);
    cyc();
    idle();
    while (sb.size() > 0) begin
      x = sb.pop_front(); n_total++;
      if (obs(x.sel) !== x.v)
        $display("FAIL coll sel%0d: got %h expected %h", x.sel, obs(x.sel), x.v);
      else n_pass++;
    end
    wr(0, 4, 32'h00000042);
    cyc();
    idle();
  endtask

  task automatic test_multiread();
    exp_t x;
    cyc();
    idle();
    wr(1, 12, 32'h0BADF00D);
    setrd(12, 12, 12);
    push(0, 32'h0BADF00D); push(1, 32'h0BADF00D);
    push(2, 32'h0BADF00D); push(4, 0);
    cyc();
    idle();
    while (sb.size() > 0) begin
      x = sb.pop_front(); n_total++;
      if (obs(x.sel) !== x.v)
        $display("FAIL mread sel%0d: got %h expected %h", x.sel, obs(x.sel), x.v);
      else n_pass++;
    end
    rsv(12);
    push(4, 32'h7); push(3, 32'h1000);
    cyc();
    idle();
    while (sb.size() > 0) begin
      x = sb.pop_front(); n_total++;
      if (obs(x.sel) !== x.v)
        $display("FAIL mread_busy sel%0d: got %h expected %h", x.sel, obs(x.sel), x.v);
      else n_pass++;
    end
    wr(0, 12, 32'h0BADF00D);
    cyc();
    idle();
  endtask

  task automatic test_back_to_back();
    exp_t        x;
    logic [4:0]  a;
    logic [4:0]  wa;
    logic [31:0] d;
    logic        b;
    logic [31:0] eb;
    @(negedge clk) rst_n = 1'b0;
    idle();
    #1 rst_n = 1'b1;
    for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
    m_busy = '0;
    for (int i = 0; i < 80; i++) begin
      cyc();
      wr_en     = 2'($urandom_range(0, 3));
      wr_addr   = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
      wr_data   = {$urandom, $urandom};
      rsv_valid = 1'($urandom_range(0, 1));
      rsv_addr  = 5'($urandom_range(0, 15));
      setrd(5'($urandom_range(0, 15)), wr_addr[4:0], 5'($urandom_range(0, 15)));
      eb = '0;
      for (int p = 0; p < NRD; p++) begin
        a = rd_addr[p*AW +: AW];
        d = m_regs[a];
        b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < NWR; w++) begin
          if (wr_en[w] && wr_addr[w*AW +: AW] == a) begin
            d = wr_data[w*XLEN +: XLEN];
            b = rsv_valid && (rsv_addr == a);
          end
        end
`endif
        if (a == 0) begin
          d = '0;
          b = 1'b0;
        end
        eb[p] = b;
        push(p, d);
      end
      push(4, eb);
      push(3, m_busy);
      #1;
      while (sb.size() > 0) begin
        x = sb.pop_front(); n_total++;
        if (obs(x.sel) !== x.v)
          $display("FAIL b2b[%0d] sel%0d: got %h expected %h", i, x.sel, obs(x.sel), x.v);
        else n_pass++;
      end
      for (int w = 0; w < NWR; w++) begin
        wa = wr_addr[w*AW +: AW];
        if (wr_en[w] && wa != 0) begin
          m_regs[wa] = wr_data[w*XLEN +: XLEN];
          m_busy[wa] = 1'b0;
        end
      end
      if (rsv_valid && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    end
    cyc();
    idle();
  endtask

  initial begin
    rst_n   = 1'b0;
    rd_addr = '0;
    idle();
    test_reset();
    test_write_latency();
    test_priority();
    test_scoreboard();
    test_collision();
    test_multiread();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
